// File: rtl/udp_chain_rx_parser_pkg.sv
// Shared constants, header offsets and state encodings for the chain receive parser.
package udp_chain_rx_parser_pkg;

    localparam logic [10:0] OFF_ETHTYPE_HI   = 11'd12;
    localparam logic [10:0] OFF_ETHTYPE_LO   = 11'd13;
    localparam logic [10:0] OFF_IP_PROTO     = 11'd23;
    localparam logic [10:0] OFF_UDP_DPORT_HI = 11'd36;
    localparam logic [10:0] OFF_UDP_DPORT_LO = 11'd37;
    localparam logic [10:0] OFF_HOP          = 11'd42;
    localparam logic [10:0] OFF_BLOCKS       = 11'd43;

    localparam logic [15:0] ETHERTYPE_IPV4      = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP        = 8'h11;
    localparam logic [15:0] CHAIN_UNUSED_SENDER = 16'hFFFF;
    localparam logic [7:0]  RMII_SFD            = 8'hD5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_DROP
    } rx_state_e;

    typedef enum logic [2:0] {
        WK_OFF,
        WK_SENDER_LO,
        WK_SENDER_HI,
        WK_LEN_LO,
        WK_LEN_HI,
        WK_PAYLOAD
    } walk_state_e;

endpackage

// File: rtl/udp_chain_rx_parser_assembler.sv
// RMII dibit-to-byte assembler: input flop, SFD hunt, dibit phase, byte strobe and end-of-frame detection.
module rmii_byte_assembler
    import udp_chain_rx_parser_pkg::*;
#(
    parameter logic [10:0] MAX_FRAME_BYTES = 11'd1522
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        phy_crsdv,
    input  logic [1:0]  phy_rxd,
    output logic [7:0]  rxd,
    output logic        rxdv,
    output logic        rxe,
    output logic        byte_stb,
    output logic [7:0]  byte_data,
    output logic [10:0] byte_off,
    output logic        sfd_stb,
    output logic        eof_stb
);

    logic        crsdv_q, crsdv_d;
    logic [1:0]  dibit_q, dibit_d;
    logic        armed_q, armed_d;
    rx_state_e   state_q, state_d;
    logic [7:0]  window_q, window_d;
    logic [1:0]  phase_q, phase_d;
    logic [5:0]  shift_q, shift_d;
    logic [10:0] offset_q, offset_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rxdv_q, rxdv_d;
    logic        rxe_q, rxe_d;

    // Carrier must be seen low once after reset before a preamble is hunted, so a frame
    // interrupted by reset is never re-locked mid-stream.
    always_comb begin
        crsdv_d   = phy_crsdv;
        dibit_d   = phy_rxd;
        armed_d   = armed_q | ~crsdv_q;
        state_d   = state_q;
        window_d  = window_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        offset_d  = offset_q;
        byte_stb  = 1'b0;
        sfd_stb   = 1'b0;
        eof_stb   = 1'b0;
        byte_data = {dibit_q, shift_q};
        byte_off  = offset_q;
        case (state_q)
            RX_IDLE: begin
                if (crsdv_q && armed_q) begin
                    state_d  = RX_PREAMBLE;
                    window_d = {dibit_q, 6'd0};
                end
            end
            RX_PREAMBLE: begin
                if (!crsdv_q) begin
                    state_d = RX_IDLE;
                end else begin
                    window_d = {dibit_q, window_q[7:2]};
                    if (window_d == RMII_SFD) begin
                        state_d  = RX_DATA;
                        phase_d  = 2'd0;
                        offset_d = 11'd0;
                        sfd_stb  = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (phase_q == 2'd0 && !crsdv_q) begin
                    state_d = RX_IDLE;
                    eof_stb = 1'b1;
                end else if (phase_q == 2'd0 && offset_q >= MAX_FRAME_BYTES) begin
                    state_d = RX_DROP;
                    eof_stb = 1'b1;
                end else begin
                    phase_d = phase_q + 2'd1;
                    shift_d = {dibit_q, shift_q[5:2]};
                    if (phase_q == 2'd3) begin
                        byte_stb = 1'b1;
                        if (offset_q != 11'h7FF) begin
                            offset_d = offset_q + 11'd1;
                        end
                    end
                end
            end
            RX_DROP: begin
                if (!crsdv_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        rxdv_d = byte_stb;
        rxe_d  = eof_stb;
        rxd_d  = byte_stb ? byte_data : rxd_q;
    end

    // crsdv_q resets high so the line must actually be observed idle before arming.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            crsdv_q  <= 1'b1;
            dibit_q  <= 2'd0;
            armed_q  <= 1'b0;
            state_q  <= RX_IDLE;
            window_q <= 8'd0;
            phase_q  <= 2'd0;
            shift_q  <= 6'd0;
            offset_q <= 11'd0;
            rxd_q    <= 8'd0;
            rxdv_q   <= 1'b0;
            rxe_q    <= 1'b0;
        end else begin
            crsdv_q  <= crsdv_d;
            dibit_q  <= dibit_d;
            armed_q  <= armed_d;
            state_q  <= state_d;
            window_q <= window_d;
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            offset_q <= offset_d;
            rxd_q    <= rxd_d;
            rxdv_q   <= rxdv_d;
            rxe_q    <= rxe_d;
        end
    end

    assign rxd  = rxd_q;
    assign rxdv = rxdv_q;
    assign rxe  = rxe_q;

endmodule

// File: rtl/udp_chain_rx_parser.sv
// Ethernet/IPv4/UDP chain-frame receive parser: header checks, hop downcount and message-block walker.
module udp_chain_rx_parser
    import udp_chain_rx_parser_pkg::*;
#(
    parameter logic [15:0] CHAIN_UDP_PORT  = 16'd11300,
    parameter logic [10:0] MAX_FRAME_BYTES = 11'd1522
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       phy_crsdv,
    input  logic [1:0] phy_rxd,
    output logic [7:0] rxd,
    output logic       rxdv,
    output logic       rxe,
    output logic       is_chain,
    output logic [7:0] hop_downcount,
    output logic       in_unused_block
);

    logic        byte_stb;
    logic [7:0]  byte_data;
    logic [10:0] byte_off;
    logic        sfd_stb;
    logic        eof_stb;

    logic        hdr_ok_q, hdr_ok_d;
    logic        is_chain_q, is_chain_d;
    logic [7:0]  hop_q, hop_d;
    logic        unused_q, unused_d;
    walk_state_e walk_q, walk_d;
    logic [7:0]  sender_lo_q, sender_lo_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] remain_q, remain_d;

    rmii_byte_assembler #(
        .MAX_FRAME_BYTES(MAX_FRAME_BYTES)
    ) u_assembler (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .phy_crsdv(phy_crsdv),
        .phy_rxd  (phy_rxd),
        .rxd      (rxd),
        .rxdv     (rxdv),
        .rxe      (rxe),
        .byte_stb (byte_stb),
        .byte_data(byte_data),
        .byte_off (byte_off),
        .sfd_stb  (sfd_stb),
        .eof_stb  (eof_stb)
    );

    // All flag updates ride on the same strobe that loads rxd, keeping them aligned with rxdv.
    always_comb begin
        hdr_ok_d    = hdr_ok_q;
        is_chain_d  = is_chain_q;
        hop_d       = hop_q;
        unused_d    = unused_q;
        walk_d      = walk_q;
        sender_lo_d = sender_lo_q;
        len_lo_d    = len_lo_q;
        remain_d    = remain_q;
        if (sfd_stb) begin
            hdr_ok_d   = 1'b1;
            is_chain_d = 1'b0;
            hop_d      = 8'd0;
            unused_d   = 1'b0;
            walk_d     = WK_OFF;
        end else if (eof_stb) begin
            unused_d = 1'b0;
            walk_d   = WK_OFF;
        end else if (byte_stb) begin
            case (byte_off)
                OFF_ETHTYPE_HI:   if (byte_data != ETHERTYPE_IPV4[15:8]) hdr_ok_d = 1'b0;
                OFF_ETHTYPE_LO:   if (byte_data != ETHERTYPE_IPV4[7:0]) hdr_ok_d = 1'b0;
                OFF_IP_PROTO:     if (byte_data != IP_PROTO_UDP) hdr_ok_d = 1'b0;
                OFF_UDP_DPORT_HI: if (byte_data != CHAIN_UDP_PORT[15:8]) hdr_ok_d = 1'b0;
                OFF_UDP_DPORT_LO: is_chain_d = hdr_ok_q && (byte_data == CHAIN_UDP_PORT[7:0]);
                OFF_HOP: begin
                    if (is_chain_q) begin
                        hop_d = (byte_data == 8'd0) ? 8'd0 : byte_data - 8'd1;
                    end
                end
                default: ;
            endcase
            if (is_chain_q) begin
                case (walk_q)
                    WK_OFF: begin
                        if (byte_off == OFF_BLOCKS) begin
                            sender_lo_d = byte_data;
                            walk_d      = WK_SENDER_HI;
                        end
                    end
                    WK_SENDER_LO: begin
                        sender_lo_d = byte_data;
                        walk_d      = WK_SENDER_HI;
                    end
                    WK_SENDER_HI: begin
                        if ({byte_data, sender_lo_q} == CHAIN_UNUSED_SENDER) begin
                            unused_d = 1'b1;
                        end
                        walk_d = WK_LEN_LO;
                    end
                    WK_LEN_LO: begin
                        len_lo_d = byte_data;
                        walk_d   = WK_LEN_HI;
                    end
                    WK_LEN_HI: begin
                        if ({byte_data, len_lo_q} == 16'd0) begin
                            walk_d = WK_SENDER_LO;
                        end else begin
                            remain_d = {byte_data, len_lo_q};
                            walk_d   = WK_PAYLOAD;
                        end
                    end
                    WK_PAYLOAD: begin
                        remain_d = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            walk_d = WK_SENDER_LO;
                        end
                    end
                    default: walk_d = WK_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hdr_ok_q    <= 1'b0;
            is_chain_q  <= 1'b0;
            hop_q       <= 8'd0;
            unused_q    <= 1'b0;
            walk_q      <= WK_OFF;
            sender_lo_q <= 8'd0;
            len_lo_q    <= 8'd0;
            remain_q    <= 16'd0;
        end else begin
            hdr_ok_q    <= hdr_ok_d;
            is_chain_q  <= is_chain_d;
            hop_q       <= hop_d;
            unused_q    <= unused_d;
            walk_q      <= walk_d;
            sender_lo_q <= sender_lo_d;
            len_lo_q    <= len_lo_d;
            remain_q    <= remain_d;
        end
    end

    assign is_chain        = is_chain_q;
    assign hop_downcount   = hop_q;
    assign in_unused_block = unused_q;

endmodule

// File: tb/tb_udp_chain_rx_parser.sv
// Directed bench for udp_chain_rx_parser: drives RMII frames and checks strobes, bytes and chain flags.
module tb_udp_chain_rx_parser;

    localparam logic [15:0] CHAIN_PORT = 16'd11300;
    localparam logic [15:0] WEB_PORT   = 16'd80;

    logic       clk_50;
    logic       rst_n;
    logic       phy_crsdv;
    logic [1:0] phy_rxd;
    logic [7:0] rxd;
    logic       rxdv;
    logic       rxe;
    logic       is_chain;
    logic [7:0] hop_downcount;
    logic       in_unused_block;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame [0:1599];
    int t0;
    int snap_rst;

    // Monitor state, written only by the monitor process.
    int cyc = 0;
    int idx = 0;
    int strobe_total = 0;
    int rxe_total = 0;
    int spacing_bad = 0;
    int overlap = 0;
    int chain_stb_total = 0;
    int unused_stb_total = 0;
    int first_stb_cyc = 0;
    int last_stb_cyc = 0;
    int rxe_cyc = 0;
    int frame_len = 0;
    logic [7:0] got_byte [0:2047];
    logic       chain_at [0:2047];
    logic [7:0] hop_at   [0:2047];
    logic       unused_at[0:2047];
    logic       chain_at_rxe;
    logic       unused_at_rxe;
    logic [7:0] hop_at_rxe;

    udp_chain_rx_parser dut (
        .clk_50         (clk_50),
        .rst_n          (rst_n),
        .phy_crsdv      (phy_crsdv),
        .phy_rxd        (phy_rxd),
        .rxd            (rxd),
        .rxdv           (rxdv),
        .rxe            (rxe),
        .is_chain       (is_chain),
        .hop_downcount  (hop_downcount),
        .in_unused_block(in_unused_block)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // Outputs are sampled on the falling edge, half a cycle away from the register updates.
    always @(negedge clk_50) begin
        cyc++;
        if (!rst_n) begin
            idx = 0;
        end else begin
            if (rxdv) begin
                if (idx > 0 && (cyc - last_stb_cyc) != 4) spacing_bad++;
                if (idx == 0) first_stb_cyc = cyc;
                last_stb_cyc = cyc;
                if (idx < 2048) begin
                    got_byte[idx]  = rxd;
                    chain_at[idx]  = is_chain;
                    hop_at[idx]    = hop_downcount;
                    unused_at[idx] = in_unused_block;
                end
                if (is_chain) chain_stb_total++;
                if (in_unused_block) unused_stb_total++;
                idx++;
                strobe_total++;
            end
            if (rxdv && rxe) overlap++;
            if (rxe) begin
                rxe_total++;
                rxe_cyc       = cyc;
                chain_at_rxe  = is_chain;
                unused_at_rxe = in_unused_block;
                hop_at_rxe    = hop_downcount;
                frame_len     = idx;
                idx = 0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_dibit(input logic crs, input logic [1:0] d);
        @(negedge clk_50);
        #1;
        phy_crsdv = crs;
        phy_rxd   = d;
    endtask

    // mode 0: filler payload; mode 1: blocks ending in an unused 0xFFFF block; mode 2: blocks with no unused marker.
    task automatic build_frame(input int len, input logic [15:0] port, input logic [7:0] hop, input int mode);
        for (int i = 0; i < len; i++) frame[i] = 8'((i * 37) + 11);
        frame[12] = 8'h08;
        frame[13] = 8'h00;
        frame[14] = 8'h45;
        frame[23] = 8'h11;
        frame[36] = port[15:8];
        frame[37] = port[7:0];
        frame[42] = hop;
        if (mode == 1) begin
            frame[43] = 8'h03; frame[44] = 8'h00; frame[45] = 8'h02; frame[46] = 8'h00;
            frame[47] = 8'hAA; frame[48] = 8'hBB;
            frame[49] = 8'h01; frame[50] = 8'h00; frame[51] = 8'h00; frame[52] = 8'h00;
            frame[53] = 8'hFF; frame[54] = 8'hFF; frame[55] = 8'h04; frame[56] = 8'h00;
        end else if (mode == 2) begin
            frame[43] = 8'h02; frame[44] = 8'h00; frame[45] = 8'h05; frame[46] = 8'h00;
            frame[52] = 8'h07; frame[53] = 8'h00; frame[54] = 8'h00; frame[55] = 8'h01;
        end
    endtask

    task automatic apply_stimulus(input int len, input int toggle_byte, input int reset_byte);
        logic [7:0] pre;
        for (int b = 0; b < 8; b++) begin
            pre = (b == 7) ? 8'hD5 : 8'h55;
            for (int i = 0; i < 4; i++) send_dibit(1'b1, pre[2*i +: 2]);
        end
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < 4; i++) begin
                send_dibit(!(b == toggle_byte && i == 2), frame[b][2*i +: 2]);
                if (b == 0 && i == 3) t0 = cyc;
                if (b == reset_byte && i == 0) rst_n = 1'b0;
                if (b == reset_byte && i == 1) begin
                    check_output("rst_rxdv", rxdv, 0);
                    check_output("rst_rxd", rxd, 0);
                    check_output("rst_is_chain", is_chain, 0);
                    check_output("rst_hop", hop_downcount, 0);
                    check_output("rst_unused", in_unused_block, 0);
                end
                if (b == reset_byte && i == 2) begin
                    rst_n = 1'b1;
                    snap_rst = strobe_total;
                end
            end
        end
        for (int i = 0; i < 48; i++) send_dibit(1'b0, 2'b00);
    endtask

    function automatic int byte_mismatches(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (got_byte[i] !== frame[i]) bad++;
        return bad;
    endfunction

    int s_stb, s_rxe, s_cst, s_ust, s_sp;

    task automatic snapshot();
        s_stb = strobe_total;
        s_rxe = rxe_total;
        s_cst = chain_stb_total;
        s_ust = unused_stb_total;
        s_sp  = spacing_bad;
    endtask

    initial begin
        rst_n     = 1'b0;
        phy_crsdv = 1'b0;
        phy_rxd   = 2'b00;
        repeat (3) @(negedge clk_50);
        #1;
        check_output("reset_rxd", rxd, 0);
        check_output("reset_rxdv", rxdv, 0);
        check_output("reset_rxe", rxe, 0);
        check_output("reset_is_chain", is_chain, 0);
        check_output("reset_hop", hop_downcount, 0);
        check_output("reset_unused", in_unused_block, 0);
        rst_n = 1'b1;
        repeat (10) send_dibit(1'b0, 2'b00);

        $display("[TB] chain frame, hop 5, unused block at offset 53");
        build_frame(80, CHAIN_PORT, 8'h05, 1);
        snapshot();
        apply_stimulus(80, -1, -1);
        check_output("chain_strobes", strobe_total - s_stb, 80);
        check_output("chain_rxe", rxe_total - s_rxe, 1);
        check_output("chain_bytes", byte_mismatches(80), 0);
        check_output("chain_latency", first_stb_cyc - t0, 2);
        check_output("chain_rxe_gap", rxe_cyc - last_stb_cyc, 1);
        check_output("chain_at36", chain_at[36], 0);
        check_output("chain_at37", chain_at[37], 1);
        check_output("hop_at41", hop_at[41], 0);
        check_output("hop_at42", hop_at[42], 8'h04);
        check_output("unused_at53", unused_at[53], 0);
        check_output("unused_at54", unused_at[54], 1);
        check_output("unused_last", unused_at[79], 1);
        check_output("unused_at_rxe", unused_at_rxe, 0);
        check_output("chain_at_rxe", chain_at_rxe, 1);
        check_output("hop_at_rxe", hop_at_rxe, 8'h04);

        $display("[TB] chain frame, hop 0, no unused marker");
        build_frame(64, CHAIN_PORT, 8'h00, 2);
        snapshot();
        apply_stimulus(64, -1, -1);
        check_output("hop0_strobes", strobe_total - s_stb, 64);
        check_output("hop0_hop_cleared", hop_at[0], 8'h00);
        check_output("hop0_chain37", chain_at[37], 1);
        check_output("hop0_hop42", hop_at[42], 8'h00);
        check_output("hop0_unused_strobes", unused_stb_total - s_ust, 0);

        $display("[TB] standard 64-byte UDP frame on port 80");
        build_frame(64, WEB_PORT, 8'h33, 0);
        snapshot();
        apply_stimulus(64, -1, -1);
        check_output("std_strobes", strobe_total - s_stb, 64);
        check_output("std_rxe", rxe_total - s_rxe, 1);
        check_output("std_bytes", byte_mismatches(64), 0);
        check_output("std_spacing", spacing_bad - s_sp, 0);
        check_output("std_chain_cleared", chain_at[0], 0);
        check_output("std_chain_strobes", chain_stb_total - s_cst, 0);
        check_output("std_unused_strobes", unused_stb_total - s_ust, 0);

        $display("[TB] carrier toggled low at phase 2 of byte 20");
        build_frame(64, WEB_PORT, 8'h33, 0);
        snapshot();
        apply_stimulus(64, 20, -1);
        check_output("tog_strobes", strobe_total - s_stb, 64);
        check_output("tog_rxe", rxe_total - s_rxe, 1);
        check_output("tog_bytes", byte_mismatches(64), 0);
        check_output("tog_spacing", spacing_bad - s_sp, 0);
        check_output("tog_frame_len", frame_len, 64);

        $display("[TB] 1600-byte frame truncated at the length limit");
        build_frame(1600, WEB_PORT, 8'h00, 0);
        snapshot();
        apply_stimulus(1600, -1, -1);
        check_output("long_strobes", strobe_total - s_stb, 1522);
        check_output("long_rxe", rxe_total - s_rxe, 1);
        check_output("long_frame_len", frame_len, 1522);
        check_output("long_bytes", byte_mismatches(1522), 0);
        check_output("long_rxe_at_limit", ((rxe_cyc - last_stb_cyc) >= 1) && ((rxe_cyc - last_stb_cyc) <= 4), 1);

        $display("[TB] reset pulsed mid chain frame, SFD pattern in remaining bytes");
        build_frame(100, CHAIN_PORT, 8'h05, 1);
        frame[70] = 8'h55;
        frame[71] = 8'h55;
        frame[72] = 8'hD5;
        snapshot();
        apply_stimulus(100, -1, 60);
        check_output("rstf_strobes_after", strobe_total - snap_rst, 0);
        check_output("rstf_rxe", rxe_total - s_rxe, 0);
        check_output("rstf_is_chain", is_chain, 0);
        check_output("rstf_unused", in_unused_block, 0);

        $display("[TB] recovery frame after reset");
        build_frame(64, WEB_PORT, 8'h33, 0);
        snapshot();
        apply_stimulus(64, -1, -1);
        check_output("rec_strobes", strobe_total - s_stb, 64);
        check_output("rec_bytes", byte_mismatches(64), 0);
        check_output("rec_rxe", rxe_total - s_rxe, 1);

        check_output("no_rxdv_rxe_overlap", overlap, 0);
        check_output("spacing_total", spacing_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
